// File: rtl/ctrl_pipe.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_pipe
// Purpose  : Carries the decoded control word through the EX, MEM and WB stages.
// Revision : 1.0
// ============================================================================
module ctrl_pipe #(
  parameter int SIZE_W     = 2,
  parameter int MEM_STAGES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [8+SIZE_W-1:0] id_signals,
  input  logic              id_valid,
  input  logic              stall,
  input  logic              flush,
  output logic              ex_valid,
  output logic              ex_RegDst,
  output logic              ex_ALUsrc,
  output logic              ex_MemRead,
  output logic              ex_Branch,
  output logic              ex_Jump,
  output logic              mem_valid,
  output logic              mem_MemRead,
  output logic              mem_MemWrite,
  output logic [SIZE_W-1:0] mem_size,
  output logic              wb_valid,
  output logic              wb_RegWrite,
  output logic              wb_MemToReg
);

  localparam int CW           = 8 + SIZE_W;
  localparam int BIT_REGDST   = CW - 1;
  localparam int BIT_ALUSRC   = CW - 2;
  localparam int BIT_REGWRITE = CW - 3;
  localparam int BIT_MEMREAD  = CW - 4;
  localparam int BIT_MEMWRITE = CW - 5;
  localparam int BIT_MEMTOREG = CW - 6;
  localparam int BIT_BRANCH   = CW - 7;
  localparam int BIT_JUMP     = CW - 8;
  localparam int MW           = 5 + SIZE_W;
  localparam int TAIL_N       = (MEM_STAGES > 1) ? MEM_STAGES - 1 : 1;

  logic          ex_valid_q, ex_valid_d;
  logic [CW-1:0] ex_word_q, ex_word_d;
  // MEM1 layout: {valid, RegWrite, MemToReg, MemRead, MemWrite, size}
  logic [MW-1:0] mem1_q, mem1_d;
  // WB and MEM tail layout: {valid, RegWrite, MemToReg}
  logic [2:0]    wb_q, wb_d;

  always_comb begin
    ex_valid_d = ex_valid_q;
    ex_word_d  = ex_word_q;
    if (flush) begin
      ex_valid_d = 1'b0;
      ex_word_d  = '0;
    end else if (!stall) begin
      ex_valid_d = id_valid;
      ex_word_d  = id_valid ? id_signals : '0;
    end
  end

  always_comb begin
    mem1_d = {ex_valid_q, ex_word_q[BIT_REGWRITE], ex_word_q[BIT_MEMTOREG],
              ex_word_q[BIT_MEMREAD], ex_word_q[BIT_MEMWRITE], ex_word_q[SIZE_W-1:0]};
    if (stall && !flush) begin
      mem1_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid_q <= 1'b0;
      ex_word_q  <= '0;
      mem1_q     <= '0;
      wb_q       <= '0;
    end else begin
      ex_valid_q <= ex_valid_d;
      ex_word_q  <= ex_word_d;
      mem1_q     <= mem1_d;
      wb_q       <= wb_d;
    end
  end

  generate
    if (MEM_STAGES == 1) begin : g_direct
      assign wb_d = mem1_q[MW-1 -: 3];
    end else begin : g_tail
      logic [2:0] tail_q [TAIL_N];
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < TAIL_N; i++) begin
            tail_q[i] <= '0;
          end
        end else begin
          tail_q[0] <= mem1_q[MW-1 -: 3];
          for (int i = 1; i < TAIL_N; i++) begin
            tail_q[i] <= tail_q[i-1];
          end
        end
      end
      assign wb_d = tail_q[TAIL_N-1];
    end
  endgenerate

  assign ex_valid     = ex_valid_q;
  assign ex_RegDst    = ex_word_q[BIT_REGDST];
  assign ex_ALUsrc    = ex_word_q[BIT_ALUSRC];
  assign ex_MemRead   = ex_word_q[BIT_MEMREAD];
  assign ex_Branch    = ex_word_q[BIT_BRANCH];
  assign ex_Jump      = ex_word_q[BIT_JUMP];

  assign mem_valid    = mem1_q[MW-1];
  assign mem_MemRead  = mem1_q[SIZE_W+1];
  assign mem_MemWrite = mem1_q[SIZE_W];
  assign mem_size     = mem1_q[SIZE_W-1:0];

  assign wb_valid     = wb_q[2];
  assign wb_RegWrite  = wb_q[1];
  assign wb_MemToReg  = wb_q[0];

endmodule
`default_nettype wire

// File: tb/tb_ctrl_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_ctrl_pipe
// Purpose  : Random and directed checks of ctrl_pipe at depths 1 and 3.
// Revision : 1.0
// ============================================================================
module tb_ctrl_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] id_signals;
  logic       id_valid, stall, flush;

  logic       ex_valid1, ex_RegDst1, ex_ALUsrc1, ex_MemRead1, ex_Branch1, ex_Jump1;
  logic       mem_valid1, mem_MemRead1, mem_MemWrite1, wb_valid1, wb_RegWrite1, wb_MemToReg1;
  logic [1:0] mem_size1;
  logic       ex_valid3, ex_RegDst3, ex_ALUsrc3, ex_MemRead3, ex_Branch3, ex_Jump3;
  logic       mem_valid3, mem_MemRead3, mem_MemWrite3, wb_valid3, wb_RegWrite3, wb_MemToReg3;
  logic [1:0] mem_size3;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference: per depth, index 0 = EX, 1..D = MEM stages, D+1 = WB; entry = {valid, word}
  logic [10:0] mdl [2][5];
  int          dep [2] = '{1, 3};

  always #5 clk = ~clk;

  ctrl_pipe #(.SIZE_W(2), .MEM_STAGES(1)) u_dut1 (
    .clk(clk), .rst(rst), .id_signals(id_signals), .id_valid(id_valid),
    .stall(stall), .flush(flush),
    .ex_valid(ex_valid1), .ex_RegDst(ex_RegDst1), .ex_ALUsrc(ex_ALUsrc1),
    .ex_MemRead(ex_MemRead1), .ex_Branch(ex_Branch1), .ex_Jump(ex_Jump1),
    .mem_valid(mem_valid1), .mem_MemRead(mem_MemRead1), .mem_MemWrite(mem_MemWrite1),
    .mem_size(mem_size1), .wb_valid(wb_valid1), .wb_RegWrite(wb_RegWrite1),
    .wb_MemToReg(wb_MemToReg1)
  );

  ctrl_pipe #(.SIZE_W(2), .MEM_STAGES(3)) u_dut3 (
    .clk(clk), .rst(rst), .id_signals(id_signals), .id_valid(id_valid),
    .stall(stall), .flush(flush),
    .ex_valid(ex_valid3), .ex_RegDst(ex_RegDst3), .ex_ALUsrc(ex_ALUsrc3),
    .ex_MemRead(ex_MemRead3), .ex_Branch(ex_Branch3), .ex_Jump(ex_Jump3),
    .mem_valid(mem_valid3), .mem_MemRead(mem_MemRead3), .mem_MemWrite(mem_MemWrite3),
    .mem_size(mem_size3), .wb_valid(wb_valid3), .wb_RegWrite(wb_RegWrite3),
    .wb_MemToReg(wb_MemToReg3)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic mdl_clear();
    for (int j = 0; j < 2; j++)
      for (int k = 0; k < 5; k++)
        mdl[j][k] = '0;
  endtask

  task automatic mdl_step(input logic s, input logic f, input logic v, input logic [9:0] w);
    for (int j = 0; j < 2; j++) begin
      for (int k = dep[j] + 1; k >= 2; k--) mdl[j][k] = mdl[j][k-1];
      mdl[j][1] = (s && !f) ? 11'd0 : mdl[j][0];
      if (f)       mdl[j][0] = 11'd0;
      else if (!s) mdl[j][0] = v ? {1'b1, w} : 11'd0;
    end
  endtask

  // Expected stage views: word bits 9..0 = RegDst,ALUsrc,RegWrite,MemRead,MemWrite,MemToReg,Branch,Jump,size
  function automatic logic [15:0] exp_ex(input logic [10:0] e);
    return {10'd0, e[10], e[9], e[8], e[6], e[3], e[2]};
  endfunction
  function automatic logic [15:0] exp_mem(input logic [10:0] e);
    return {11'd0, e[10], e[6], e[5], e[1:0]};
  endfunction
  function automatic logic [15:0] exp_wb(input logic [10:0] e);
    return {13'd0, e[10], e[7], e[4]};
  endfunction

  task automatic check_all();
    chk("ex_d1",  {10'd0, ex_valid1, ex_RegDst1, ex_ALUsrc1, ex_MemRead1, ex_Branch1, ex_Jump1},
        exp_ex(mdl[0][0]));
    chk("mem_d1", {11'd0, mem_valid1, mem_MemRead1, mem_MemWrite1, mem_size1}, exp_mem(mdl[0][1]));
    chk("wb_d1",  {13'd0, wb_valid1, wb_RegWrite1, wb_MemToReg1}, exp_wb(mdl[0][2]));
    chk("ex_d3",  {10'd0, ex_valid3, ex_RegDst3, ex_ALUsrc3, ex_MemRead3, ex_Branch3, ex_Jump3},
        exp_ex(mdl[1][0]));
    chk("mem_d3", {11'd0, mem_valid3, mem_MemRead3, mem_MemWrite3, mem_size3}, exp_mem(mdl[1][1]));
    chk("wb_d3",  {13'd0, wb_valid3, wb_RegWrite3, wb_MemToReg3}, exp_wb(mdl[1][4]));
  endtask

  task automatic all_zero(input string tag);
    chk(tag, {ex_valid1, ex_RegDst1, ex_ALUsrc1, ex_MemRead1, ex_Branch1, ex_Jump1,
              mem_valid1, mem_MemRead1, mem_MemWrite1, mem_size1, wb_valid1, wb_RegWrite1,
              wb_MemToReg1, 2'b00}, 16'd0);
    chk({tag, "_d3"}, {ex_valid3, ex_RegDst3, ex_ALUsrc3, ex_MemRead3, ex_Branch3, ex_Jump3,
              mem_valid3, mem_MemRead3, mem_MemWrite3, mem_size3, wb_valid3, wb_RegWrite3,
              wb_MemToReg3, 2'b00}, 16'd0);
  endtask

  // Called just after a falling edge: drive, clock once, check at the next falling edge.
  task automatic cyc(input logic s, input logic f, input logic v, input logic [9:0] w);
    stall = s; flush = f; id_valid = v; id_signals = w;
    @(posedge clk);
    mdl_step(s, f, v, w);
    @(negedge clk);
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 10'd0);
  endtask

  // Assert reset in the low phase, confirm outputs clear without a clock edge.
  task automatic mid_reset(input string tag);
    #2 rst = 1'b1;
    #1 all_zero(tag);
    mdl_clear();
    @(posedge clk);
    @(negedge clk);
    all_zero({tag, "_hold"});
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; id_signals = '0; id_valid = 1'b0; stall = 1'b0; flush = 1'b0;
    mdl_clear();
    #1 all_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    // Load flow with explicit latencies for both depths
    cyc(1'b0, 1'b0, 1'b1, 10'h1D2);
    chk("load_e1", {ex_valid1, ex_ALUsrc1, ex_MemRead1}, 16'h7);
    cyc(1'b0, 1'b0, 1'b0, 10'd0);
    chk("load_e2", {mem_MemRead1, mem_size1, mem_MemRead3}, 16'hD);
    chk("load_e2_wb3", {wb_RegWrite3}, 16'd0);
    cyc(1'b0, 1'b0, 1'b0, 10'd0);
    chk("load_e3", {wb_RegWrite1, wb_MemToReg1, wb_RegWrite3}, 16'h6);
    cyc(1'b0, 1'b0, 1'b0, 10'd0);
    chk("load_e4_wb3", {wb_RegWrite3}, 16'd0);
    cyc(1'b0, 1'b0, 1'b0, 10'd0);
    chk("load_e5_wb3", {wb_RegWrite3, wb_MemToReg3}, 16'h3);
    idle(2);

    // Stall with A in EX; B only captured once stall drops
    cyc(1'b0, 1'b0, 1'b1, 10'h1D2);
    cyc(1'b1, 1'b0, 1'b1, 10'h280);
    chk("stall_hold", {ex_valid1, ex_ALUsrc1, mem_valid1}, 16'h6);
    cyc(1'b0, 1'b0, 1'b1, 10'h280);
    chk("stall_b_ex", {ex_valid1, ex_RegDst1, ex_ALUsrc1}, 16'h6);
    idle(3);

    // Flushed store never reaches memory
    cyc(1'b0, 1'b1, 1'b1, 10'h122);
    chk("flush_ex", {ex_valid1}, 16'd0);
    for (int i = 0; i < 4; i++) begin
      chk("flush_mw", {mem_MemWrite1, mem_MemWrite3}, 16'd0);
      cyc(1'b0, 1'b0, 1'b0, 10'd0);
    end

    // Stall and flush together: flush wins, EX word moves on to MEM1
    cyc(1'b0, 1'b0, 1'b1, 10'h1D2);
    cyc(1'b1, 1'b1, 1'b1, 10'h280);
    chk("sf_ex", {ex_valid1}, 16'd0);
    chk("sf_mem", {mem_valid1, mem_MemRead1}, 16'h3);
    idle(2);

    // Reset mid-stream, then normal latency afterwards
    cyc(1'b0, 1'b0, 1'b1, 10'h1D2);
    cyc(1'b0, 1'b0, 1'b1, 10'h280);
    cyc(1'b0, 1'b0, 1'b1, 10'h122);
    mid_reset("midrst");
    cyc(1'b0, 1'b0, 1'b1, 10'h1D2);
    chk("post_rst_ex", {ex_valid1, ex_MemRead1}, 16'h3);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 63) == 0) begin
        mid_reset("rnd_rst");
      end else begin
        cyc($urandom_range(0, 3) == 0, $urandom_range(0, 6) == 0,
            $urandom_range(0, 3) != 0, 10'($urandom));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
